// File: rtl/opd_stage.sv
// rtl/opd_stage.sv - registered opcode decode stage with load-use hazard bubble and flush

package opd_pkg;

  localparam int OPCODES_WIDTH = 4;

  // Instruction opcodes; codes 10..15 are unused and decode as illegal.
  typedef enum logic [OPCODES_WIDTH-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_LW  = 4'd5,
    OP_SW  = 4'd6,
    OP_BEQ = 4'd7,
    OP_BLT = 4'd8,
    OP_BLE = 4'd9
  } opcodes_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    CMP_NOP = 2'd0,
    CMP_BEQ = 2'd1,
    CMP_BLT = 2'd2,
    CMP_BLE = 2'd3
  } cmp_op_e;

endpackage

module opd_stage
  import opd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_REG = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [XLEN-1:0]            i_instruction,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(NUM_REG)-1:0] o_select_a,
  output logic [$clog2(NUM_REG)-1:0] o_select_b,
  output logic [$clog2(NUM_REG)-1:0] o_select_c,
  output logic                       o_is_write,
  output logic                       o_is_load,
  output logic                       o_is_store,
  output logic                       o_is_cmp,
  output cmp_op_e                    o_cmp_op,
  output alu_op_e                    o_alu_op,
  output logic [XLEN-1:0]            o_offset,
  output logic                       o_illegal,
  output logic [CNT_W-1:0]           o_bubble_cnt
);

  localparam int REG_SELECT = $clog2(NUM_REG);
  localparam int IMM_W      = XLEN - OPCODES_WIDTH - 2*REG_SELECT;

  // Instruction fields: opcode | sel_a | sel_b | immediate (sel_c = top of immediate)
  logic [OPCODES_WIDTH-1:0] in_opc;
  logic [REG_SELECT-1:0]    in_sel_a;
  logic [REG_SELECT-1:0]    in_sel_b;
  logic [REG_SELECT-1:0]    in_sel_c;
  logic [IMM_W-1:0]         in_imm;
  logic [XLEN-1:0]          imm_sext;
  logic [XLEN-1:0]          imm_branch;

  assign in_opc     = i_instruction[XLEN-1 -: OPCODES_WIDTH];
  assign in_sel_a   = i_instruction[XLEN-OPCODES_WIDTH-1 -: REG_SELECT];
  assign in_sel_b   = i_instruction[XLEN-OPCODES_WIDTH-REG_SELECT-1 -: REG_SELECT];
  assign in_imm     = i_instruction[IMM_W-1:0];
  assign in_sel_c   = in_imm[IMM_W-1 -: REG_SELECT];
  assign imm_sext   = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign imm_branch = {imm_sext[XLEN-3:0], 2'b00};

  // Decoded bundle for the incoming instruction, before it is registered
  logic            d_write;
  logic            d_load;
  logic            d_store;
  logic            d_cmp;
  cmp_op_e         d_cmp_op;
  alu_op_e         d_alu_op;
  logic [XLEN-1:0] d_offset;
  logic            d_illegal;
  logic            d_reads_a;
  logic            d_reads_b;

  // Decode table plus which source registers the incoming instruction reads
  always_comb begin
    d_write   = 1'b0;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_cmp     = 1'b0;
    d_cmp_op  = CMP_NOP;
    d_alu_op  = ALU_ADD;
    d_offset  = '0;
    d_illegal = 1'b0;
    d_reads_a = 1'b0;
    d_reads_b = 1'b0;
    case (in_opc)
      OP_ADD: begin d_write = 1'b1; d_alu_op = ALU_ADD; d_reads_a = 1'b1; d_reads_b = 1'b1; end
      OP_SUB: begin d_write = 1'b1; d_alu_op = ALU_SUB; d_reads_a = 1'b1; d_reads_b = 1'b1; end
      OP_AND: begin d_write = 1'b1; d_alu_op = ALU_AND; d_reads_a = 1'b1; d_reads_b = 1'b1; end
      OP_OR:  begin d_write = 1'b1; d_alu_op = ALU_OR;  d_reads_a = 1'b1; d_reads_b = 1'b1; end
      OP_XOR: begin d_write = 1'b1; d_alu_op = ALU_XOR; d_reads_a = 1'b1; d_reads_b = 1'b1; end
      OP_LW: begin
        d_write   = 1'b1;
        d_load    = 1'b1;
        d_offset  = imm_sext;
        d_reads_a = 1'b1;
      end
      OP_SW: begin
        d_store   = 1'b1;
        d_offset  = imm_sext;
        d_reads_a = 1'b1;
        d_reads_b = 1'b1;
      end
      OP_BEQ, OP_BLT, OP_BLE: begin
        d_cmp     = 1'b1;
        d_cmp_op  = (in_opc == OP_BEQ) ? CMP_BEQ :
                    (in_opc == OP_BLT) ? CMP_BLT : CMP_BLE;
        d_offset  = imm_branch;
        d_reads_a = 1'b1;
        d_reads_b = 1'b1;
      end
      default: begin
        d_alu_op  = ALU_OR;
        d_illegal = 1'b1;
      end
    endcase
  end

  // A load in the output register writes sel_b; any incoming read of it must wait a cycle
  logic hazard;
  assign hazard = o_valid && o_is_load &&
                  ((d_reads_a && (in_sel_a == o_select_b)) ||
                   (d_reads_b && (in_sel_b == o_select_b)));

  assign o_ready = (!o_valid || i_ready) && !hazard && !i_flush;

  // Pipeline register: capture on handshake, bubble on load-use, hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_select_a   <= '0;
      o_select_b   <= '0;
      o_select_c   <= '0;
      o_is_write   <= 1'b0;
      o_is_load    <= 1'b0;
      o_is_store   <= 1'b0;
      o_is_cmp     <= 1'b0;
      o_cmp_op     <= CMP_NOP;
      o_alu_op     <= ALU_ADD;
      o_offset     <= '0;
      o_illegal    <= 1'b0;
      o_bubble_cnt <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_valid && o_ready) begin
      o_valid    <= 1'b1;
      o_select_a <= in_sel_a;
      o_select_b <= in_sel_b;
      o_select_c <= in_sel_c;
      o_is_write <= d_write;
      o_is_load  <= d_load;
      o_is_store <= d_store;
      o_is_cmp   <= d_cmp;
      o_cmp_op   <= d_cmp_op;
      o_alu_op   <= d_alu_op;
      o_offset   <= d_offset;
      o_illegal  <= d_illegal;
    end else if (i_valid && hazard && i_ready) begin
      o_valid <= 1'b0;
      if (!(&o_bubble_cnt)) begin
        o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
      end
    end else if (o_valid && !i_ready) begin
      o_valid <= o_valid;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opd_stage.sv
// tb/tb_opd_stage.sv - self-checking bench for opd_stage with a behavioural reference model
module tb_opd_stage;
  import opd_pkg::*;

  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_instruction = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [4:0]  o_select_a, o_select_b, o_select_c;
  logic        o_is_write, o_is_load, o_is_store, o_is_cmp;
  cmp_op_e     o_cmp_op;
  alu_op_e     o_alu_op;
  logic [31:0] o_offset;
  logic        o_illegal;
  logic [CW-1:0] o_bubble_cnt;

  int total = 0;
  int bad   = 0;

  opd_stage #(.XLEN(32), .NUM_REG(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_instruction(i_instruction), .o_valid(o_valid), .i_ready(i_ready),
    .o_select_a(o_select_a), .o_select_b(o_select_b), .o_select_c(o_select_c),
    .o_is_write(o_is_write), .o_is_load(o_is_load), .o_is_store(o_is_store),
    .o_is_cmp(o_is_cmp), .o_cmp_op(o_cmp_op), .o_alu_op(o_alu_op),
    .o_offset(o_offset), .o_illegal(o_illegal), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  sa, sb, sc;
    logic        w, l, s, c;
    logic [1:0]  cmp;
    logic [2:0]  alu;
    logic [31:0] off;
    logic        ill;
  } bundle_t;

  // Reference state: what the execute side should see
  logic        m_valid = 1'b0;
  bundle_t     m_b = '0;
  int          m_cnt = 0;

  function automatic logic [31:0] mk(input int op, input int a, input int b, input int imm);
    logic [31:0] r;
    r = {op[3:0], a[4:0], b[4:0], imm[17:0]};
    return r;
  endfunction

  // Decode rules written by opcode category
  function automatic bundle_t ref_decode(input logic [31:0] ins);
    bundle_t r;
    int op, s;
    op = int'(ins[31:28]);
    s  = int'($signed(ins[17:0]));
    r = '0;
    r.sa = ins[27:23];
    r.sb = ins[22:18];
    r.sc = ins[17:13];
    if (op <= 4) begin
      r.w = 1'b1;
      r.alu = (op == 0) ? ALU_ADD : (op == 1) ? ALU_SUB : (op == 2) ? ALU_AND :
              (op == 3) ? ALU_OR : ALU_XOR;
    end else if (op == 5) begin
      r.w = 1'b1; r.l = 1'b1; r.alu = ALU_ADD; r.off = s;
    end else if (op == 6) begin
      r.s = 1'b1; r.alu = ALU_ADD; r.off = s;
    end else if (op <= 9) begin
      r.c = 1'b1; r.alu = ALU_ADD; r.off = s * 4;
      r.cmp = (op == 7) ? CMP_BEQ : (op == 8) ? CMP_BLT : CMP_BLE;
    end else begin
      r.ill = 1'b1; r.alu = ALU_OR;
    end
    return r;
  endfunction

  function automatic logic ref_hazard(input logic [31:0] ins);
    int op;
    logic ra, rb;
    op = int'(ins[31:28]);
    ra = (op <= 9);
    rb = (op <= 4) || (op >= 6 && op <= 9);
    return m_valid && m_b.l && ((ra && ins[27:23] == m_b.sb) || (rb && ins[22:18] == m_b.sb));
  endfunction

  function automatic logic ref_ready();
    return (!m_valid || i_ready) && !ref_hazard(i_instruction) && !i_flush;
  endfunction

  function automatic logic [65:0] observed();
    bundle_t b;
    b = {o_select_a, o_select_b, o_select_c, o_is_write, o_is_load, o_is_store, o_is_cmp,
         o_cmp_op, o_alu_op, o_offset, o_illegal};
    return {o_valid, o_bubble_cnt, b};
  endfunction

  function automatic logic [65:0] expected();
    logic [CW-1:0] c;
    c = m_cnt[CW-1:0];
    return {m_valid, c, m_b};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_valid = 1'b0; m_b = '0; m_cnt = 0;
    end else if (i_flush) begin
      m_valid = 1'b0;
    end else if (i_valid && ref_ready()) begin
      m_valid = 1'b1; m_b = ref_decode(i_instruction);
    end else if (i_valid && ref_hazard(i_instruction) && i_ready) begin
      m_valid = 1'b0;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (m_valid && !i_ready) begin
      m_valid = m_valid;
    end else if (i_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    i_valid = v; i_instruction = ins; i_ready = rdy; i_flush = fl;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    total++;
    if (observed() !== 66'd0) begin
      bad++; $display("FAIL reset_state obs=%h exp=%h", observed(), 66'd0);
    end
  endtask

  task automatic test_add();
    drive(1'b1, mk(0, 1, 2, 3 << 13), 1'b1, 1'b0);
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL add_ready obs=%b exp=1", o_ready); end
    tick();
    total++;
    if ({o_valid, o_alu_op, o_is_write, o_select_a, o_select_b, o_select_c, o_offset} !==
        {1'b1, ALU_ADD, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0}) begin
      bad++; $display("FAIL add_bundle obs=%h exp=%h", observed(), expected());
    end
  endtask

  task automatic test_branch();
    drive(1'b1, mk(7, 3, 4, 18'h3FFFF), 1'b1, 1'b0);
    tick();
    total++;
    if ({o_valid, o_offset, o_cmp_op, o_is_cmp} !== {1'b1, 32'hFFFF_FFFC, CMP_BEQ, 1'b1}) begin
      bad++; $display("FAIL beq_offset obs=%h/%0d/%b exp=FFFFFFFC/BEQ/1", o_offset, o_cmp_op, o_is_cmp);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, mk(5, 1, 5, 4), 1'b1, 1'b0);
    tick();
    total++;
    if ({o_valid, o_is_load, o_offset} !== {1'b1, 1'b1, 32'd4}) begin
      bad++; $display("FAIL lw_issue obs=%h exp=%h", observed(), expected());
    end
    drive(1'b1, mk(0, 5, 0, 6 << 13), 1'b1, 1'b0);
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL lu_stall_ready obs=%b exp=0", o_ready); end
    tick();
    total++;
    if ({o_valid, o_bubble_cnt} !== {1'b0, 8'd1}) begin
      bad++; $display("FAIL lu_bubble obs=%b/%0d exp=0/1", o_valid, o_bubble_cnt);
    end
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL lu_release_ready obs=%b exp=1", o_ready); end
    tick();
    total++;
    if ({o_valid, o_select_a, o_select_c, o_alu_op, o_bubble_cnt} !== {1'b1, 5'd5, 5'd6, ALU_ADD, 8'd1}) begin
      bad++; $display("FAIL lu_add_issue obs=%h exp=%h", observed(), expected());
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, mk(0, 1, 2, 3 << 13), 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(1, 4, 5, 6 << 13), 1'b0, 1'b0);
      total++;
      if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d obs=%b exp=0", k, o_ready); end
      tick();
      total++;
      if ({o_valid, o_alu_op, o_select_a, o_select_b, o_select_c, o_bubble_cnt} !==
          {1'b1, ALU_ADD, 5'd1, 5'd2, 5'd3, 8'd1}) begin
        bad++; $display("FAIL bp_hold cyc=%0d obs=%h exp=%h", k, observed(), expected());
      end
    end
    drive(1'b1, mk(1, 4, 5, 6 << 13), 1'b1, 1'b0);
    tick();
    total++;
    if ({o_valid, o_alu_op, o_select_a, o_select_b, o_select_c} !== {1'b1, ALU_SUB, 5'd4, 5'd5, 5'd6}) begin
      bad++; $display("FAIL bp_resume obs=%h exp=%h", observed(), expected());
    end
  endtask

  task automatic test_flush();
    int c0;
    drive(1'b1, mk(5, 1, 7, 8), 1'b1, 1'b0);
    tick();
    c0 = m_cnt;
    drive(1'b1, mk(0, 7, 2, 0), 1'b1, 1'b1);
    tick();
    total++;
    if ({o_valid, o_bubble_cnt} !== {1'b0, c0[CW-1:0]}) begin
      bad++; $display("FAIL flush_kill obs=%b/%0d exp=0/%0d", o_valid, o_bubble_cnt, c0);
    end
    drive(1'b1, mk(0, 7, 2, 0), 1'b1, 1'b0);
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_rearm obs=%b exp=1", o_ready); end
    tick();
    total++;
    if ({o_valid, o_select_a, o_bubble_cnt} !== {1'b1, 5'd7, c0[CW-1:0]}) begin
      bad++; $display("FAIL flush_reissue obs=%h exp=%h", observed(), expected());
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, mk(k % 5, k + 8, k + 16, 0), 1'b1, 1'b0);
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d obs=%b exp=1", k, o_ready); end
      tick();
      total++;
      if ({o_valid, o_select_a} !== {1'b1, 5'(k + 8)}) begin
        bad++; $display("FAIL b2b_issue k=%0d obs=%b/%0d exp=1/%0d", k, o_valid, o_select_a, k + 8);
      end
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, mk(12, 9, 10, 18'h2ABCD), 1'b1, 1'b0);
    tick();
    total++;
    if ({o_valid, o_illegal, o_is_write, o_is_load, o_is_store, o_is_cmp, o_alu_op, o_cmp_op, o_offset} !==
        {1'b1, 1'b1, 4'b0000, ALU_OR, CMP_NOP, 32'd0}) begin
      bad++; $display("FAIL illegal_decode obs=%h exp=%h", observed(), expected());
    end
  endtask

  task automatic test_saturate();
    drive(1'b1, mk(5, 5, 5, 0), 1'b1, 1'b0);
    for (int k = 0; k < 2 * ((1 << CW) + 3) + 4; k++) begin
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL sat_step k=%0d obs=%h exp=%h", k, observed(), expected());
      end
    end
    total++;
    if (o_bubble_cnt !== {CW{1'b1}}) begin
      bad++; $display("FAIL sat_value obs=%0d exp=%0d", o_bubble_cnt, (1 << CW) - 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    rst = 1'b1; drive(1'b0, '0, 1'b1, 1'b0); tick(); rst = 1'b0;
    for (int k = 0; k < 400; k++) begin
      ins = mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 262143));
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 75, ins, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
      if (!rst) begin
        total++;
        if (o_ready !== ref_ready()) begin
          bad++; $display("FAIL rnd_ready k=%0d obs=%b exp=%b", k, o_ready, ref_ready());
        end
      end
      tick();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL rnd_state k=%0d obs=%h exp=%h", k, observed(), expected());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load_use();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_illegal();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
